// File: rtl/debounce_pkg.sv
// Shared constants and state encoding for the multi-channel debouncer.
// Imported by debounce_channel and debounce_bank.
package debounce_pkg;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } deb_state_e;

    localparam int DEB_CHANNELS_DEFAULT = 4;
    localparam int DEB_STABLE_DEFAULT   = 16;
    localparam int DEB_SYNC_DEFAULT     = 2;

    // Counter width large enough to hold 0..stable_cycles.
    function automatic int deb_cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: synchroniser chain, stability counter and commit FSM.
// out changes only after the synchronised input differs for STABLE_CYCLES ticks.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_STABLE  | synchronised input matches out; counter idle at 0
//   ST_PENDING | input differs from out; cnt counts consecutive differing ticks
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEB_STABLE_DEFAULT,
    parameter int SYNC_STAGES   = DEB_SYNC_DEFAULT
) (
    input  logic clock,
    input  logic nreset,
    input  logic din,
    input  logic tick,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W    = deb_cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    deb_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   commit;

    // Synchroniser runs every clock, independent of tick.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        if (tick) begin
            case (state_q)
                ST_STABLE: begin
                    if (sync != out_q) begin
                        // A single required tick means the first differing sample commits.
                        if (STABLE_CYCLES == 1) begin
                            commit = 1'b1;
                        end else begin
                            state_d = ST_PENDING;
                            cnt_d   = CNT_ONE;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                ST_PENDING: begin
                    if (sync == out_q) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        commit = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            endcase
            if (commit) begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        end
    end

    assign out_d  = commit ? sync : out_q;
    assign rise_d = commit & sync;
    assign fall_d = commit & ~sync;

    assign dout = out_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer for raw buttons/switches with per-channel edge pulses.
// Channels are independent; the top only fans out clock, reset and tick.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS      = DEB_CHANNELS_DEFAULT,
    parameter int STABLE_CYCLES = DEB_STABLE_DEFAULT,
    parameter int SYNC_STAGES   = DEB_SYNC_DEFAULT
) (
    input  logic                clock,
    input  logic                nreset,
    input  logic [CHANNELS-1:0] in,
    input  logic                tick,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES)
        ) u_ch (
            .clock  (clock),
            .nreset (nreset),
            .din    (in[i]),
            .tick   (tick),
            .dout   (out[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

endmodule
